// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with clock filter,
// request-to-send inhibit, acknowledge capture and edge timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_ps2,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick,
    output logic       ack
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RTS   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_ACKW  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

    logic [1:0]  c_sync;
    logic [1:0]  d_sync;
    logic [7:0]  c_filt;
    logic        c_f;
    logic        fall_tick;
    logic [2:0]  state;
    logic [9:0]  frame;
    logic [3:0]  bit_cnt;
    logic [20:0] cnt;
    logic        ack_q;
    logic        done_q;
    logic        active;
    logic        timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_filt <= 8'hFF;
            c_f    <= 1'b1;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
            c_filt <= {c_sync[1], c_filt[7:1]};
            if (c_filt == 8'h00)
                c_f <= 1'b0;
            else if (c_filt == 8'hFF)
                c_f <= 1'b1;
        end
    end

    assign fall_tick = c_f & (c_filt == 8'h00);

    assign active  = (state == S_DATA) | (state == S_ACKW) |
                     (state == S_FIN);
    assign timeout = active & ~fall_tick & (cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            frame   <= 10'h3FF;
            bit_cnt <= 4'd0;
            cnt     <= 21'd0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_ps2) begin
                        frame <= {1'b1, ~^din, din};
                        cnt   <= 21'd0;
                        state <= S_RTS;
                    end
                end
                S_RTS: begin
                    if (cnt == INH_LAST)
                        state <= S_START;
                    else
                        cnt <= cnt + 21'd1;
                end
                S_START: begin
                    bit_cnt <= 4'd0;
                    cnt     <= 21'd0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (fall_tick) begin
                        cnt <= 21'd0;
                        // first edge only ends the start bit; shift on the rest
                        if (bit_cnt != 4'd0)
                            frame <= {1'b1, frame[9:1]};
                        if (bit_cnt != 4'd15)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9)
                            state <= S_ACKW;
                    end else if (timeout) begin
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                S_ACKW: begin
                    if (fall_tick) begin
                        ack_q <= ~d_sync[1];
                        cnt   <= 21'd0;
                        state <= S_FIN;
                    end else if (timeout) begin
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                S_FIN: begin
                    if (c_f && d_sync[1]) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else if (timeout) begin
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 21'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ps2c_oe      = (state == S_RTS) | (state == S_START);
        ps2d_oe      = (state == S_START) |
                       ((state == S_DATA) &
                        ((bit_cnt == 4'd0) | ~frame[0]));
        tx_idle      = (state == S_IDLE);
        tx_done_tick = done_q;
        tx_err_tick  = timeout;
        ack          = ack_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on open-drain lines,
// scoreboard of expected frames checked at each tx_done_tick.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 16;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       a;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_ps2 = 1'b0;
    logic       kb_clk = 1'b1;
    logic       kb_dat = 1'b1;
    logic       ps2c_line;
    logic       ps2d_line;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;
    logic       ack;

    exp_t       sb[$];
    exp_t       e;
    logic [9:0] rx_bits = 10'h000;
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_fall = -1;
    int         err_at = -1;
    int         n_done = 0;

    assign ps2c_line = kb_clk & ~ps2c_oe;
    assign ps2d_line = kb_dat & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .wr_ps2(wr_ps2),
        .ps2c_in(ps2c_line),
        .ps2d_in(ps2d_line),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick(tx_err_tick),
        .ack(ack)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dut.fall_tick)
            last_fall <= cyc;
        if (tx_err_tick)
            err_at <= cyc;
        if (tx_done_tick) begin
            n_done <= n_done + 1;
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data", 32'(rx_bits[7:0]), 32'(e.d));
                check("parity", 32'(rx_bits[8]), 32'(e.p));
                check("stop", 32'(rx_bits[9]), 1);
                check("ack", 32'(ack), 32'(e.a));
            end
        end
    end

    task automatic kb_device(input int nfalls, input logic ack_low,
                             input bit glitch);
        int w;
        w = 0;
        while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("host_request", 32'(ps2c_oe == 1'b0 && ps2d_oe == 1'b1), 1);
        repeat (HALF) @(negedge clk);
        if (glitch) begin
            kb_clk = 1'b0;
            repeat (5) @(negedge clk);
            kb_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < nfalls; i++) begin
            kb_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 10)
                rx_bits[i] = ps2d_line;
            kb_clk = 1'b1;
            if (i == 9 && ack_low)
                kb_dat = 1'b0;
            if (i == 10)
                kb_dat = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic ack_low,
                              input bit glitch, input bit timing,
                              input bit dup, input int nfalls);
        int   nd0;
        int   cc;
        int   fd;
        logic c18;
        logic idle1;
        nd0 = n_done;
        cc  = 0;
        fd  = 0;
        c18 = 1'b1;
        idle1 = 1'b1;
        din = d;
        wr_ps2 = 1'b1;
        if (nfalls == 11)
            sb.push_back(exp_t'{d: d, p: ($countones(d) % 2 == 0),
                                a: ack_low});
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j <= 17 && ps2c_oe)
                cc++;
            if (fd == 0 && ps2d_oe)
                fd = j;
            if (j == 18)
                c18 = ps2c_oe;
            if (j == 1) begin
                idle1 = tx_idle;
                wr_ps2 = 1'b0;
            end
            if (dup && j == 3) begin
                din = 8'h3C;
                wr_ps2 = 1'b1;
            end
            if (j == 4)
                wr_ps2 = 1'b0;
        end
        if (timing) begin
            check("idle_drop", 32'(idle1), 0);
            check("rts_clk_len", 32'(cc), 17);
            check("start_data_cycle", 32'(fd), 17);
            check("clk_release", 32'(c18), 0);
        end
        kb_device(nfalls, ack_low, glitch);
        repeat (30) @(negedge clk);
        check("done_count", 32'(n_done - nd0), (nfalls == 11) ? 1 : 0);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst_c_oe", 32'(ps2c_oe), 0);
        check("rst_d_oe", 32'(ps2d_oe), 0);
        check("rst_idle", 32'(tx_idle), 1);
        check("rst_done", 32'(tx_done_tick), 0);
        check("rst_err", 32'(tx_err_tick), 0);
        check("rst_ack", 32'(ack), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 11);
        send_frame(8'hF4, 1'b1, 1'b0, 1'b0, 1'b0, 11);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 11);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 11);
        check("busy_no_second", 32'(tx_idle), 1);
        check("busy_ack_held", 32'(ack), 1);

        send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        w = 0;
        while (err_at < 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("err_seen", 32'(err_at >= 0), 1);
        check("err_gap", 32'(err_at - last_fall), TO);
        @(negedge clk);
        check("err_c_oe", 32'(ps2c_oe), 0);
        check("err_d_oe", 32'(ps2d_oe), 0);
        check("err_ack", 32'(ack), 0);
        check("err_idle", 32'(tx_idle), 1);

        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        check("pre_rst_d_oe", 32'(ps2d_oe), 1);
        check("pre_rst_busy", 32'(tx_idle), 0);
        reset = 1'b0;
        #1;
        check("arst_c_oe", 32'(ps2c_oe), 0);
        check("arst_d_oe", 32'(ps2d_oe), 0);
        check("arst_idle", 32'(tx_idle), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
